ahb_cmd_master: RTL and testbench

Synthesizable AHB3-Lite initiator that turns a simple valid/ready command stream into single AHB transfers. It returns one response per command: read data or write completion, plus an error flag. It is the initiator-side counterpart of the existing AHB slaves (`ahb_ram`, `dahb_ram`, `ahb_interconnect`), used as a traffic generator / debug-access master in benches and SoC tops. It supports the standard AHB overlap of one address phase with one data phase, wait states, and the two-cycle ERROR response.

---
 rtl/ahb_cmd_master_if.sv | 41 ++++
 rtl/ahb_cmd_master.sv | 117 +++++++++++
 tb/tb_ahb_cmd_master.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_cmd_master_if.sv
// Bus bundle for ahb_cmd_master: command/response stream plus the AHB3-Lite
// master/slave signals. The master modport is the initiator's view.
interface ahb_cmd_master_if;
  logic        s_cmd_valid_i;
  logic        s_cmd_ready_o;
  logic [31:0] s_cmd_addr_i;
  logic        s_cmd_write_i;
  logic [2:0]  s_cmd_size_i;
  logic [31:0] s_cmd_wdata_i;
  logic        s_rsp_valid_o;
  logic [31:0] s_rsp_rdata_o;
  logic        s_rsp_err_o;
  logic        s_busy_o;
  logic [31:0] s_haddr_o;
  logic [1:0]  s_htrans_o;
  logic        s_hwrite_o;
  logic [2:0]  s_hsize_o;
  logic [2:0]  s_hburst_o;
  logic [3:0]  s_hprot_o;
  logic        s_hmastlock_o;
  logic [31:0] s_hwdata_o;
  logic [31:0] s_hrdata_i;
  logic        s_hready_i;
  logic        s_hresp_i;

  modport master (
    input  s_cmd_valid_i, s_cmd_addr_i, s_cmd_write_i, s_cmd_size_i, s_cmd_wdata_i,
    input  s_hrdata_i, s_hready_i, s_hresp_i,
    output s_cmd_ready_o, s_rsp_valid_o, s_rsp_rdata_o, s_rsp_err_o, s_busy_o,
    output s_haddr_o, s_htrans_o, s_hwrite_o, s_hsize_o, s_hburst_o, s_hprot_o,
    output s_hmastlock_o, s_hwdata_o
  );

  modport slave (
    output s_cmd_valid_i, s_cmd_addr_i, s_cmd_write_i, s_cmd_size_i, s_cmd_wdata_i,
    output s_hrdata_i, s_hready_i, s_hresp_i,
    input  s_cmd_ready_o, s_rsp_valid_o, s_rsp_rdata_o, s_rsp_err_o, s_busy_o,
    input  s_haddr_o, s_htrans_o, s_hwrite_o, s_hsize_o, s_hburst_o, s_hprot_o,
    input  s_hmastlock_o, s_hwdata_o
  );
endinterface

// File: rtl/ahb_cmd_master.sv
// AHB3-Lite initiator: turns a valid/ready command stream into SINGLE transfers
// with one overlapped address/data phase and in-order responses.
module ahb_cmd_master (
  input  logic          s_clk_i,
  input  logic          s_rst_i,
  ahb_cmd_master_if.master bus
);
  logic        a_vld_q, a_vld_d;
  logic [31:0] a_addr_q, a_addr_d;
  logic        a_write_q, a_write_d;
  logic [2:0]  a_size_q, a_size_d;
  logic [31:0] a_wdata_q, a_wdata_d;
  logic        d_vld_q, d_vld_d;
  logic        d_write_q, d_write_d;
  logic [31:0] d_wdata_q, d_wdata_d;
  logic        cancel_q, cancel_d;
  logic        rsp_vld_q, rsp_vld_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic a_issue;
  logic cmd_ready;
  logic accept;

  // A cancelled address phase is suppressed to IDLE but its contents are kept.
  assign a_issue   = a_vld_q & ~cancel_q;
  assign cmd_ready = ~s_rst_i & (~a_vld_q | (bus.s_hready_i & ~cancel_q));
  assign accept    = bus.s_cmd_valid_i & cmd_ready;

  always_comb begin
    a_vld_d     = a_vld_q;
    a_addr_d    = a_addr_q;
    a_write_d   = a_write_q;
    a_size_d    = a_size_q;
    a_wdata_d   = a_wdata_q;
    d_vld_d     = d_vld_q;
    d_write_d   = d_write_q;
    d_wdata_d   = d_wdata_q;
    cancel_d    = cancel_q;
    rsp_vld_d   = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;

    if (bus.s_hready_i) begin
      d_vld_d   = a_issue;
      d_write_d = a_write_q;
      d_wdata_d = a_write_q ? a_wdata_q : '0;
      if (a_issue) a_vld_d = 1'b0;
    end

    if (accept) begin
      a_vld_d   = 1'b1;
      a_addr_d  = bus.s_cmd_addr_i;
      a_write_d = bus.s_cmd_write_i;
      a_size_d  = bus.s_cmd_size_i;
      a_wdata_d = bus.s_cmd_wdata_i;
    end

    if (d_vld_q && bus.s_hready_i) begin
      rsp_vld_d   = 1'b1;
      rsp_rdata_d = (!d_write_q && !bus.s_hresp_i) ? bus.s_hrdata_i : '0;
      rsp_err_d   = bus.s_hresp_i;
    end

    // First ERROR cycle forces IDLE on the following cycle; an ERROR seen
    // together with HREADY completes immediately without cancelling.
    if (d_vld_q && bus.s_hresp_i && !bus.s_hready_i) begin
      cancel_d = 1'b1;
    end else if (bus.s_hready_i) begin
      cancel_d = 1'b0;
    end
  end

  always_ff @(posedge s_clk_i) begin
    if (s_rst_i) begin
      a_vld_q     <= 1'b0;
      a_addr_q    <= '0;
      a_write_q   <= 1'b0;
      a_size_q    <= '0;
      a_wdata_q   <= '0;
      d_vld_q     <= 1'b0;
      d_write_q   <= 1'b0;
      d_wdata_q   <= '0;
      cancel_q    <= 1'b0;
      rsp_vld_q   <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      a_vld_q     <= a_vld_d;
      a_addr_q    <= a_addr_d;
      a_write_q   <= a_write_d;
      a_size_q    <= a_size_d;
      a_wdata_q   <= a_wdata_d;
      d_vld_q     <= d_vld_d;
      d_write_q   <= d_write_d;
      d_wdata_q   <= d_wdata_d;
      cancel_q    <= cancel_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.s_cmd_ready_o = cmd_ready;
  assign bus.s_rsp_valid_o = rsp_vld_q;
  assign bus.s_rsp_rdata_o = rsp_rdata_q;
  assign bus.s_rsp_err_o   = rsp_err_q;
  assign bus.s_busy_o      = a_vld_q | d_vld_q;
  assign bus.s_haddr_o     = a_addr_q;
  assign bus.s_htrans_o    = a_issue ? 2'b10 : 2'b00;
  assign bus.s_hwrite_o    = a_write_q;
  assign bus.s_hsize_o     = a_size_q;
  assign bus.s_hburst_o    = 3'b000;
  assign bus.s_hprot_o     = 4'b0011;
  assign bus.s_hmastlock_o = 1'b0;
  assign bus.s_hwdata_o    = d_vld_q ? d_wdata_q : '0;
endmodule

// File: tb/tb_ahb_cmd_master.sv
// Bench for ahb_cmd_master: behavioural AHB slave with wait states and an
// ERROR region (addr[31]=1), directed scenarios, then randomized traffic.
module tb_ahb_cmd_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ahb_cmd_master_if bus_if ();
  ahb_cmd_master dut (.s_clk_i(clk), .s_rst_i(rst), .bus(bus_if));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  function automatic logic [31:0] init_val(int i);
    return (i == 4) ? 32'hDEADBEEF : {16'hC0DE, 16'(i)};
  endfunction

  // ---------------- behavioural AHB slave ----------------
  logic [31:0] mem [64];
  bit          mem_init = 1'b1;
  int          wmax  = 0;
  bit          wrand = 1'b0;
  logic        dp_v = 1'b0, dp_wr = 1'b0, dp_err = 1'b0, err2 = 1'b0;
  logic [31:0] dp_addr = '0;
  int          wait_cnt = 0;

  assign bus_if.s_hready_i = !dp_v || (dp_err ? err2 : (wait_cnt == 0));
  assign bus_if.s_hresp_i  = dp_v && dp_err;
  assign bus_if.s_hrdata_i = (dp_v && !dp_wr && !dp_err && wait_cnt == 0) ? mem[dp_addr[7:2]] : 32'h0;

  always_ff @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
    end else if (!rst && bus_if.s_hready_i && dp_v && dp_wr && !dp_err) begin
      mem[dp_addr[7:2]] <= bus_if.s_hwdata_o;
    end
    if (rst) begin
      dp_v <= 1'b0; err2 <= 1'b0; wait_cnt <= 0;
    end else if (bus_if.s_hready_i) begin
      dp_v     <= (bus_if.s_htrans_o == 2'b10);
      dp_addr  <= bus_if.s_haddr_o;
      dp_wr    <= bus_if.s_hwrite_o;
      dp_err   <= bus_if.s_haddr_o[31];
      err2     <= 1'b0;
      wait_cnt <= wrand ? int'($urandom_range(32'(wmax), 0)) : wmax;
    end else if (dp_err) begin
      err2 <= 1'b1;
    end else begin
      wait_cnt <= wait_cnt - 1;
    end
  end

  // ---------------- reference model: in-order expected responses ----------------
  typedef struct { logic [31:0] rdata; logic err; } rsp_t;
  rsp_t        exp_q[$];
  logic [31:0] ref_mem [64];
  bit          acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_ref(input logic [31:0] addr, input logic wr, input logic [31:0] wdata);
    rsp_t r;
    r.err = addr[31];
    if (wr && !r.err) ref_mem[addr[7:2]] = wdata;
    r.rdata = (!wr && !r.err) ? ref_mem[addr[7:2]] : 32'h0;
    exp_q.push_back(r);
  endtask

  task automatic tick();
    rsp_t r;
    @(negedge clk);
    acc = bus_if.s_cmd_valid_i && bus_if.s_cmd_ready_o;
    if (acc) push_ref(bus_if.s_cmd_addr_i, bus_if.s_cmd_write_i, bus_if.s_cmd_wdata_i);
    @(posedge clk);
    #1;
    cyc++;
    if (bus_if.s_rsp_valid_o) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        r = exp_q.pop_front();
        chk("rsp_rdata", bus_if.s_rsp_rdata_o, r.rdata);
        chk("rsp_err", 32'(bus_if.s_rsp_err_o), 32'(r.err));
      end
    end
    chk("outstanding_le2", 32'(exp_q.size() > 2), 32'd0);
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic w,
                       input logic [2:0] s, input logic [31:0] d);
    bus_if.s_cmd_valid_i = v;
    bus_if.s_cmd_addr_i  = a;
    bus_if.s_cmd_write_i = w;
    bus_if.s_cmd_size_i  = s;
    bus_if.s_cmd_wdata_i = d;
  endtask

  // Presents one command and returns in the cycle after its handshake.
  task automatic send(input logic [31:0] a, input logic w, input logic [2:0] s, input logic [31:0] d);
    int n = 0;
    drive(1'b1, a, w, s, d);
    tick();
    while (!acc && n < 20) begin tick(); n++; end
    if (!acc) chk("send_timeout", 32'd1, 32'd0);
    bus_if.s_cmd_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    bus_if.s_cmd_valid_i = 1'b0;
    while ((exp_q.size() != 0 || bus_if.s_busy_o) && n < 100) begin tick(); n++; end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    tick();
  endtask

  initial begin
    drive(1'b0, '0, 1'b0, 3'd0, '0);
    for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
    repeat (3) @(posedge clk);
    #1;
    mem_init = 1'b0;

    // reset state
    chk("rst_ready", 32'(bus_if.s_cmd_ready_o), 32'd0);
    chk("rst_htrans", 32'(bus_if.s_htrans_o), 32'd0);
    chk("rst_haddr", bus_if.s_haddr_o, 32'd0);
    chk("rst_hwdata", bus_if.s_hwdata_o, 32'd0);
    chk("rst_busy", 32'(bus_if.s_busy_o), 32'd0);
    chk("rst_rsp_valid", 32'(bus_if.s_rsp_valid_o), 32'd0);
    chk("hburst", 32'(bus_if.s_hburst_o), 32'd0);
    chk("hprot", 32'(bus_if.s_hprot_o), 32'h3);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(bus_if.s_cmd_ready_o), 32'd1);

    // single read, zero wait states
    send(32'h10, 1'b0, 3'd2, 32'h0);
    chk("rd_htrans_c1", 32'(bus_if.s_htrans_o), 32'h2);
    chk("rd_haddr_c1", bus_if.s_haddr_o, 32'h10);
    tick();
    chk("rd_no_rsp_c2", 32'(bus_if.s_rsp_valid_o), 32'd0);
    tick();
    chk("rd_rsp_c3", 32'(bus_if.s_rsp_valid_o), 32'd1);
    chk("rd_rdata_c3", bus_if.s_rsp_rdata_o, 32'hDEADBEEF);
    drain();

    // write then immediate read of the same word
    send(32'h20, 1'b1, 3'd2, 32'h12345678);
    send(32'h20, 1'b0, 3'd2, 32'h0);
    chk("wr_hwdata", bus_if.s_hwdata_o, 32'h12345678);
    chk("wr_rd_overlap_htrans", 32'(bus_if.s_htrans_o), 32'h2);
    chk("wr_rd_overlap_hwrite", 32'(bus_if.s_hwrite_o), 32'd0);
    tick();
    chk("wr_rsp", 32'(bus_if.s_rsp_valid_o), 32'd1);
    tick();
    chk("rd_after_wr_rsp", 32'(bus_if.s_rsp_valid_o), 32'd1);
    chk("rd_after_wr_rdata", bus_if.s_rsp_rdata_o, 32'h12345678);
    drain();

    // two wait states on a read with a second command pending in A
    wmax = 2;
    send(32'h10, 1'b0, 3'd2, 32'h0);
    send(32'h24, 1'b0, 3'd2, 32'h0);
    for (int k = 0; k < 2; k++) begin
      chk("ws_hready", 32'(bus_if.s_hready_i), 32'd0);
      chk("ws_htrans", 32'(bus_if.s_htrans_o), 32'h2);
      chk("ws_haddr", bus_if.s_haddr_o, 32'h24);
      chk("ws_hwdata", bus_if.s_hwdata_o, 32'h0);
      chk("ws_ready", 32'(bus_if.s_cmd_ready_o), 32'd0);
      tick();
    end
    chk("ws_no_rsp_c4", 32'(bus_if.s_rsp_valid_o), 32'd0);
    tick();
    chk("ws_rsp_c5", 32'(bus_if.s_rsp_valid_o), 32'd1);
    chk("ws_rdata_c5", bus_if.s_rsp_rdata_o, 32'hDEADBEEF);
    drain();

    // ERROR write with a read already in its address phase
    wmax = 0;
    send(32'h8000_0040, 1'b1, 3'd2, 32'h55);
    send(32'h10, 1'b0, 3'd2, 32'h0);
    chk("err1_hresp", 32'(bus_if.s_hresp_i), 32'd1);
    chk("err1_htrans", 32'(bus_if.s_htrans_o), 32'h2);
    tick();
    chk("err2_htrans_idle", 32'(bus_if.s_htrans_o), 32'h0);
    tick();
    chk("err_wr_rsp", 32'(bus_if.s_rsp_valid_o), 32'd1);
    chk("err_wr_rsp_err", 32'(bus_if.s_rsp_err_o), 32'd1);
    chk("err_rd_represent", 32'(bus_if.s_htrans_o), 32'h2);
    chk("err_rd_haddr", bus_if.s_haddr_o, 32'h10);
    tick();
    tick();
    chk("err_rd_rsp", 32'(bus_if.s_rsp_valid_o), 32'd1);
    chk("err_rd_rsp_err", 32'(bus_if.s_rsp_err_o), 32'd0);
    drain();

    // byte write
    send(32'h23, 1'b1, 3'd0, 32'hAB);
    chk("byte_hsize", 32'(bus_if.s_hsize_o), 32'd0);
    chk("byte_haddr", bus_if.s_haddr_o, 32'h23);
    chk("byte_hwrite", 32'(bus_if.s_hwrite_o), 32'd1);
    drain();

    // randomized traffic with random wait states and ERROR region
    wrand = 1'b1;
    wmax  = 2;
    for (int k = 0; k < 400; k++) begin
      if (!bus_if.s_cmd_valid_i || acc) begin
        drive($urandom_range(3, 0) != 0,
              {($urandom_range(7, 0) == 0), 23'h0, 6'($urandom_range(63, 0)), 2'b00},
              1'($urandom_range(1, 0)), 3'd2, $urandom);
      end
      tick();
    end
    drain();

    // reset during a wait-stated read data phase
    wrand = 1'b0;
    wmax  = 3;
    send(32'h10, 1'b0, 3'd2, 32'h0);
    tick();
    chk("rst_ws_hready", 32'(bus_if.s_hready_i), 32'd0);
    rst = 1'b1;
    tick();
    chk("abort_htrans", 32'(bus_if.s_htrans_o), 32'h0);
    chk("abort_haddr", bus_if.s_haddr_o, 32'h0);
    chk("abort_hwrite", 32'(bus_if.s_hwrite_o), 32'd0);
    chk("abort_hsize", 32'(bus_if.s_hsize_o), 32'd0);
    chk("abort_hwdata", bus_if.s_hwdata_o, 32'h0);
    chk("abort_rsp_valid", 32'(bus_if.s_rsp_valid_o), 32'd0);
    chk("abort_rsp_rdata", bus_if.s_rsp_rdata_o, 32'h0);
    chk("abort_rsp_err", 32'(bus_if.s_rsp_err_o), 32'd0);
    chk("abort_busy", 32'(bus_if.s_busy_o), 32'd0);
    chk("abort_ready", 32'(bus_if.s_cmd_ready_o), 32'd0);
    exp_q.delete();
    rst = 1'b0;
    tick();
    chk("after_rst_ready", 32'(bus_if.s_cmd_ready_o), 32'd1);
    chk("after_rst_no_rsp", 32'(bus_if.s_rsp_valid_o), 32'd0);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
